// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared APB definitions used by the APB master bridge and the
//             APB register slave: default bus widths and the master FSM
//             state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package apb_pkg;

    localparam int c_apb_datawidth = 32;
    localparam int c_apb_addrwidth = 8;

    // Master FSM encoding; the slave side decodes the same values.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b10,
        S_RESP   = 2'b11
    } apb_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_wait_timer
//  Purpose  : Counts ACCESS wait-state cycles and flags when the limit of
//             TIMEOUT_CYCLES-1 counted waits has been reached.
//  Ports    : clk, rst_n   clock / asynchronous active-low reset
//             clear        zero the count (driven during SETUP)
//             enable       count this cycle (ACCESS with PREADY low)
//             expired      count has reached TIMEOUT_CYCLES-1
//  Revision : 1.0  initial release
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_limit);

endmodule : apb_wait_timer
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_bridge
//  Purpose  : Converts single host commands (valid/ready) into APB transfers
//             and returns the result on a response channel. One transfer is
//             outstanding at a time: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  Ports    : PCLK, PRESETn            clock / asynchronous active-low reset
//             cmd_valid/ready/write/addr/wdata   host command channel
//             rsp_valid/ready/rdata/err          host response channel
//             PSEL/PWRITE/PADDR/PWDATA/PRDATA/PREADY   APB requester side
//  Config   : APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees
//             no PREADY for TIMEOUT_CYCLES cycles ends with rsp_err=1.
//             Undefined: ACCESS waits indefinitely and rsp_err is 0.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DATAWIDTH      = c_apb_datawidth,
    parameter int ADDRWIDTH      = c_apb_addrwidth,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 PSEL,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0] PWDATA,
    input  logic [DATAWIDTH-1:0] PRDATA,
    input  logic                 PREADY
);

    apb_state_t           r_state;
    logic                 r_cmd_ready;
    logic                 r_psel;
    logic                 r_pwrite;
    logic [ADDRWIDTH-1:0] r_paddr;
    logic [DATAWIDTH-1:0] r_pwdata;
    logic                 r_rsp_valid;
    logic [DATAWIDTH-1:0] r_rsp_rdata;
    logic                 w_expired;

    // A zero-length limit cannot be represented by the wait timer.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    logic r_rsp_err;

    // Cleared in SETUP so the count starts at zero on ACCESS entry.
    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (r_state == S_SETUP),
        .enable  ((r_state == S_ACCESS) && !PREADY),
        .expired (w_expired)
    );

    assign rsp_err = r_rsp_err;
`else
    assign w_expired = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
                        r_psel      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    // PREADY takes priority over an expiring timer.
                    if (PREADY) begin
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_psel      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_expired) begin
                        r_rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b1;
`endif
                        r_psel      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // No bypass: a command offered alongside rsp_ready is
                    // taken on the following cycle from IDLE.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign PSEL      = r_psel;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule : apb_master_bridge
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_bridge
//  Purpose  : Self-checking bench for apb_master_bridge. A register-array
//             slave answers the bus; a transaction-level model predicts every
//             output each cycle. Directed scenarios pin the model with
//             literal expectations, then random traffic runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready, rsp_valid, rsp_err;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY = 1'b0;

    logic [DW-1:0] mem [256];
    assign PRDATA = mem[PADDR];

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .DATAWIDTH      (DW),
        .ADDRWIDTH      (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: is a transfer in flight, has the bus phase
    // finished, how many bus cycles it has used, and the transfer fields.
    bit            m_busy, m_resp, m_started;
    int            m_waits;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_err;

    int n_psel, n_cyc, first_rsp;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_started = 0; m_waits = 0;
        m_write = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
    endtask

    // Advance the model by one clock using the inputs presented before it.
    task automatic model_step();
        if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1; m_started = 0;
                m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
            end
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_busy = 0; m_resp = 0;
            end
        end else if (!m_started) begin
            m_started = 1; m_waits = 0;          // first bus cycle is SETUP
        end else if (PREADY) begin
            m_resp = 1; m_err = 0;
            if (m_write) begin
                mem[m_addr] = m_wdata;
                m_rdata = '0;
            end else begin
                m_rdata = mem[m_addr];
            end
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (m_waits == TO - 1) begin
            m_resp = 1; m_err = 1; m_rdata = '0;
`endif
        end else begin
            m_waits++;
        end
    endtask

    task automatic compare();
        chk("psel",      {31'd0, PSEL},      {31'd0, m_busy && !m_resp});
        chk("pwrite",    {31'd0, PWRITE},    {31'd0, m_write});
        chk("paddr",     {24'd0, PADDR},     {24'd0, m_addr});
        chk("pwdata",    PWDATA,             m_wdata);
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_busy});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
        chk("rsp_rdata", rsp_rdata,          m_rdata);
        chk("rsp_err",   {31'd0, rsp_err},   {31'd0, m_err});
    endtask

    task automatic cycle(input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit pr, input bit rr);
        cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        PREADY = pr; rsp_ready = rr;
        model_step();
        @(posedge PCLK);
        @(negedge PCLK);
        compare();
        n_cyc++;
        if (PSEL) n_psel++;
        if (rsp_valid && first_rsp == 0) first_rsp = n_cyc;
    endtask

    task automatic idle();
        cycle(0, 0, '0, '0, 0, 1);
    endtask

    task automatic mark();
        n_psel = 0; n_cyc = 0; first_rsp = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_busy; i++) cycle(0, 0, '0, '0, 1, 1);
        chk("drain_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_psel",      {31'd0, PSEL},      32'd0);
        chk("reset_pwrite",    {31'd0, PWRITE},    32'd0);
        chk("reset_paddr",     {24'd0, PADDR},     32'd0);
        chk("reset_pwdata",    PWDATA,             32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata,          32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
        PRESETn = 1'b1;
        idle();
        chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Zero-wait write
        mark();
        cycle(1, 1, 8'h05, 32'hDEADBEEF, 1, 1);
        cycle(0, 0, '0, '0, 1, 1);
        cycle(0, 0, '0, '0, 1, 1);
        chk("wr_psel_cycles", n_psel, 32'd2);
        chk("wr_rsp_cycle",   first_rsp, 32'd3);
        chk("wr_paddr",       {24'd0, PADDR}, 32'h05);
        chk("wr_pwrite",      {31'd0, PWRITE}, 32'd1);
        chk("wr_pwdata",      PWDATA, 32'hDEADBEEF);
        chk("wr_rsp_rdata",   rsp_rdata, 32'd0);
        chk("wr_rsp_err",     {31'd0, rsp_err}, 32'd0);
        idle();

        // Read back the same register
        cycle(1, 0, 8'h05, 32'h0, 1, 1);
        cycle(0, 0, '0, '0, 1, 1);
        cycle(0, 0, '0, '0, 1, 1);
        chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        idle();

        // Three wait states on a read of the top address
        mark();
        cycle(1, 0, 8'hFF, 32'h0, 0, 1);
        cycle(0, 0, '0, '0, 0, 1);
        repeat (3) cycle(0, 0, '0, '0, 0, 1);
        chk("ws_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        cycle(0, 0, '0, '0, 1, 1);
        chk("ws_psel_cycles", n_psel, 32'd5);
        chk("ws_rsp_cycle",   first_rsp, 32'd6);
        chk("ws_paddr",       {24'd0, PADDR}, 32'hFF);

        // Response back-pressure with a command waiting
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 8'h33, 32'h1234_5678, 1, 0);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_psel",      {31'd0, PSEL},      32'd0);
        end
        cycle(1, 1, 8'h33, 32'h1234_5678, 1, 1);
        chk("bp_release_psel",  {31'd0, PSEL},      32'd0);
        chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
        cycle(1, 1, 8'h33, 32'h1234_5678, 1, 1);
        chk("bp_next_accept", {31'd0, PSEL}, 32'd1);
        drain();

        // Reset in the middle of ACCESS
        cycle(1, 0, 8'h40, 32'h0, 0, 1);
        cycle(0, 0, '0, '0, 0, 1);
        cycle(0, 0, '0, '0, 0, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_mid_psel",      {31'd0, PSEL},      32'd0);
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        model_reset();
        @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        idle();
        chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never answers: error after TO ACCESS cycles
        cycle(1, 0, 8'h10, 32'h0, 0, 1);
        cycle(0, 0, '0, '0, 0, 1);
        repeat (TO - 1) cycle(0, 0, '0, '0, 0, 1);
        chk("to_not_yet", {31'd0, rsp_valid}, 32'd0);
        cycle(0, 0, '0, '0, 0, 1);
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_err",   {31'd0, rsp_err},   32'd1);
        chk("to_rsp_rdata", rsp_rdata,          32'd0);
        idle();
        cycle(1, 1, 8'h11, 32'hCAFE_F00D, 1, 1);
        cycle(0, 0, '0, '0, 1, 1);
        cycle(0, 0, '0, '0, 1, 1);
        chk("to_after_err", {31'd0, rsp_err}, 32'd0);
        idle();
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                  AW'($urandom), $urandom,
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 70);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_master_bridge
`default_nettype wire
